cbus_rr_arbiter: RTL and testbench

- N-way round-robin arbiter that shares the single cbus port (RAMHelper2 / MMIO side) among cbus masters: IBusToCBus, DBusToCBus, and future DMA/uncached masters.
- Starvation guard: any requester that has waited MAX_WAIT cycles wins the next grant.
- One transaction (single beat or burst) is granted at a time and held until the last beat completes.
- Sits between the bus converters and the memory helper; exposes debug taps for the perf counters.

---
 rtl/cbus_rr_arbiter_pkg.sv | 27 ++
 rtl/cbus_rr_arbiter_rr_pick.sv | 41 ++++
 rtl/cbus_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus types and arbiter constants.
package cbus_rr_arbiter_pkg;

  localparam int unsigned CBUS_ADDR_W          = 32;
  localparam int unsigned CBUS_DATA_W          = 64;
  localparam int unsigned ARB_MAX_WAIT_DEFAULT = 15;

  typedef struct packed {
    logic                     valid;
    logic                     is_write;
    logic [2:0]               size;
    logic [CBUS_ADDR_W-1:0]   addr;
    logic [CBUS_DATA_W/8-1:0] strobe;
    logic [CBUS_DATA_W-1:0]   data;
    logic [3:0]               len;    // beats - 1
    logic [1:0]               burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational winner selection: starvation first (lowest saturated index), else round-robin.
module cbus_rr_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  input  logic [NUM_REQ-1:0] sat_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               is_starve_o
);

  logic [NUM_REQ-1:0] starve_vec;
  logic [IDX_W-1:0]   cand;
  logic               found;

  // Saturated requesters pre-empt the rotation; otherwise scan from rr_ptr with wrap.
  always_comb begin
    winner_o    = '0;
    is_starve_o = 1'b0;
    found       = 1'b0;
    cand        = '0;
    starve_vec  = valid_i & sat_i;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!is_starve_o && starve_vec[i]) begin
        winner_o    = IDX_W'(i);
        is_starve_o = 1'b1;
      end
    end
    if (!is_starve_o) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = IDX_W'((32'(rr_ptr_i) + k) % NUM_REQ);
        if (!found && valid_i[cand]) begin
          winner_o = cand;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cbus slave among NUM_REQ masters, with a starvation guard.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned MAX_WAIT = ARB_MAX_WAIT_DEFAULT,
  parameter int unsigned WAIT_W   = $clog2(MAX_WAIT + 1),
  // Derived; leave at default.
  parameter int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  cbus_req_t  [NUM_REQ-1:0] ireqs,
  output cbus_resp_t [NUM_REQ-1:0] iresps,
  output cbus_req_t                oreq,
  input  cbus_resp_t               oresp,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     starve_grant
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               starve_q, starve_d;
  logic [WAIT_W-1:0]  wait_q [NUM_REQ];
  logic [WAIT_W-1:0]  wait_d [NUM_REQ];

  logic [NUM_REQ-1:0] valid_vec, sat_vec, grant_now, is_owner;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_starve;
  logic               any_valid;
  logic               done;

  assign any_valid = |valid_vec;
  assign done      = oresp.ready && oresp.last;

  // Per-requester status vectors feeding the picker and the wait counters.
  always_comb begin
    valid_vec = '0;
    sat_vec   = '0;
    grant_now = '0;
    is_owner  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      valid_vec[i] = ireqs[i].valid;
      sat_vec[i]   = (wait_q[i] == WAIT_W'(MAX_WAIT));
      grant_now[i] = (state_q == ARB_IDLE) && any_valid && (pick_idx == IDX_W'(i));
      is_owner[i]  = (state_q == ARB_BUSY) && (grant_q == IDX_W'(i));
    end
  end

  cbus_rr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid_i     (valid_vec),
    .rr_ptr_i    (rr_ptr_q),
    .sat_i       (sat_vec),
    .winner_o    (pick_idx),
    .is_starve_o (pick_starve)
  );

  // FSM next state: grant from IDLE, hold through BUSY until the last beat completes.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    starve_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          state_d  = ARB_BUSY;
          grant_d  = pick_idx;
          starve_d = pick_starve;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Wait counters: saturating count of cycles spent valid but not owning the bus.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (!valid_vec[i] || grant_now[i] || is_owner[i]) begin
        wait_d[i] = '0;
      end else if (!sat_vec[i]) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      starve_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
    end
  end

  // Bus steering: forward the grantee only while BUSY, everything quiet otherwise.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == ARB_BUSY) begin
      oreq            = ireqs[grant_q];
      iresps[grant_q] = oresp;
    end
  end

  assign busy         = (state_q == ARB_BUSY);
  assign grant_idx    = grant_q;
  assign starve_grant = starve_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scoreboard bench: expected grants are queued with the stimulus and popped when busy rises.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned MAXW = 4;
  localparam int unsigned IW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  cbus_req_t  [NREQ-1:0] ireqs;
  cbus_resp_t [NREQ-1:0] iresps;
  cbus_req_t             oreq;
  cbus_resp_t            oresp;
  logic                  busy;
  logic [IW-1:0]         grant_idx;
  logic                  starve_grant;

  always #5 clk = ~clk;

  cbus_rr_arbiter #(
    .NUM_REQ  (NREQ),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ireqs        (ireqs),
    .iresps       (iresps),
    .oreq         (oreq),
    .oresp        (oresp),
    .busy         (busy),
    .grant_idx    (grant_idx),
    .starve_grant (starve_grant)
  );

  typedef struct {
    int idx;
    bit starve;
    int gap;  // -1: don't care
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pend  [NREQ];
  bit   done_f[NREQ];
  int   beat;
  bit   busy_prev;
  int   idle_run;
  bit   rst_edge;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic cbus_req_t mk_req(input int i, input int len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = i[0];
    r.size     = 3'd3;
    r.addr     = 32'(32'h1000 * (i + 1));
    r.strobe   = '1;
    r.data     = 64'(i) * 64'h0101_0101_0101_0101;
    r.len      = 4'(len);
    r.burst    = 2'b01;
    return r;
  endfunction

  task automatic issue(input int i, input int len, input int extra);
    ireqs[i] = mk_req(i, len);
    pend[i]  = extra;
  endtask

  task automatic push_exp(input int idx, input bit starve, input int gap);
    exp_t e;
    e.idx    = idx;
    e.starve = starve;
    e.gap    = gap;
    exp_q.push_back(e);
  endtask

  // Slave: always ready while a request is presented, last on beat == len.
  task automatic slave_respond();
    if (oreq.valid === 1'b1) begin
      oresp.ready = 1'b1;
      oresp.last  = (beat == int'(oreq.len));
      oresp.data  = 64'(oreq.addr) + 64'(beat);
    end else begin
      oresp = '0;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (busy === 1'b1 && busy_prev == 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 128'(exp_q.size()), 128'(1));
      end else begin
        e = exp_q.pop_front();
        chk("grant_idx", 128'(grant_idx), 128'(e.idx));
        chk("starve_grant", 128'(starve_grant), 128'(e.starve));
        chk("oreq_addr", 128'(oreq.addr), 128'(32'h1000 * (e.idx + 1)));
        if (e.gap >= 0) chk("idle_gap", 128'(idle_run), 128'(e.gap));
      end
      idle_run = 0;
    end else begin
      chk("starve_quiet", 128'(starve_grant), 128'(0));
      if (busy !== 1'b1) idle_run++;
    end
    busy_prev = (busy === 1'b1);
  endtask

  task automatic cycle();
    #1;
    slave_respond();
    #1;
    for (int i = 0; i < NREQ; i++) done_f[i] = (iresps[i].ready === 1'b1) && (iresps[i].last === 1'b1);
    rst_edge = reset;
    @(posedge clk);
    #1;
    if (rst_edge) beat = 0;
    else if (oresp.ready && oresp.last) beat = 0;
    else if (oresp.ready) beat++;
    if (!rst_edge) begin
      for (int i = 0; i < NREQ; i++) begin
        if (done_f[i]) begin
          if (pend[i] > 0) pend[i]--;
          else ireqs[i] = '0;
        end
      end
    end
    monitor();
  endtask

  function automatic bit any_master();
    bit a = 1'b0;
    for (int i = 0; i < NREQ; i++) if (ireqs[i].valid) a = 1'b1;
    return a;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || any_master()) && n < 300) begin
      cycle();
      n++;
    end
    chk({tag, "_exp_left"}, 128'(exp_q.size()), 128'(0));
    chk({tag, "_idle_end"}, 128'(busy), 128'(0));
  endtask

  initial begin
    ireqs     = '0;
    oresp     = '0;
    reset     = 1'b1;
    beat      = 0;
    busy_prev = 1'b0;
    idle_run  = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;

    // Reset then idle
    repeat (2) cycle();
    reset = 1'b0;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant_idx", 128'(grant_idx), 128'(0));
    chk("rst_starve", 128'(starve_grant), 128'(0));
    chk("rst_oreq", 128'(oreq), 128'(0));
    for (int i = 0; i < NREQ; i++) chk("rst_iresps", 128'(iresps[i]), 128'(0));
    repeat (2) cycle();

    // Single request from master 1, one beat
    push_exp(1, 1'b0, -1);
    issue(1, 0, 0);
    #1;
    chk("t1_pre_valid", 128'(oreq.valid), 128'(0));
    cycle();
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_oreq_valid", 128'(oreq.valid), 128'(1));
    #1;
    slave_respond();
    #1;
    chk("t1_iresp1_ready", 128'(iresps[1].ready), 128'(1));
    chk("t1_iresp0_zero", 128'(iresps[0]), 128'(0));
    cycle();
    chk("t1_busy_fall", 128'(busy), 128'(0));
    chk("t1_oreq_idle", 128'(oreq), 128'(0));
    drain("t1");

    // Contention: rr_ptr=2 after t1, so order is 0,1,0,1,0,1 with one idle cycle between
    for (int k = 0; k < 3; k++) begin
      push_exp(0, 1'b0, (k == 0) ? -1 : 1);
      push_exp(1, 1'b0, 1);
    end
    issue(0, 0, 2);
    issue(1, 0, 2);
    drain("t2");

    // Burst hold: 4-beat burst from 0, master 1 arrives at beat 2
    push_exp(0, 1'b0, -1);
    issue(0, 3, 0);
    cycle();
    chk("t3_b1_grant", 128'(grant_idx), 128'(0));
    cycle();
    issue(1, 0, 0);
    push_exp(1, 1'b0, 1);
    cycle();
    chk("t3_b3_grant", 128'(grant_idx), 128'(0));
    chk("t3_b3_busy", 128'(busy), 128'(1));
    cycle();
    chk("t3_b4_grant", 128'(grant_idx), 128'(0));
    chk("t3_b4_busy", 128'(busy), 128'(1));
    cycle();
    chk("t3_after_busy", 128'(busy), 128'(0));
    chk("t3_after_grant", 128'(grant_idx), 128'(0));
    drain("t3");

    // Reset during beat 2 of a 4-beat burst from master 1
    push_exp(1, 1'b0, -1);
    issue(1, 3, 0);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ireqs = '0;
    chk("t4_rst_busy", 128'(busy), 128'(0));
    chk("t4_rst_oreq", 128'(oreq), 128'(0));
    chk("t4_rst_grant", 128'(grant_idx), 128'(0));
    for (int i = 0; i < NREQ; i++) chk("t4_rst_iresps", 128'(iresps[i]), 128'(0));

    // Starvation: rr_ptr back at 0, master 2 saturates during an 8-beat burst from 0
    // and pre-empts the rotation (which would pick 1); 1 follows without starvation.
    push_exp(0, 1'b0, -1);
    push_exp(2, 1'b1, 1);
    push_exp(1, 1'b0, 1);
    issue(0, 7, 0);
    issue(2, 0, 0);
    cycle();
    repeat (7) cycle();
    chk("t5_b8_busy", 128'(busy), 128'(1));
    issue(1, 0, 0);
    drain("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
